// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the register-file write-port controller.
package regfile_pkg;

   localparam int DATA_W     = 64;
   localparam int ADDR_W     = 5;
   localparam int NREG       = 32;
   localparam int ZERO_REG   = 31;
   localparam int STARVE_MAX = 3;

   typedef enum logic {INIT, RUN} wctl_state_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/wb_starve_arbiter.sv
// Two-requester write-port arbiter: A has priority, B is forced through after
// STARVE_MAX consecutive denials.
module wb_starve_arbiter #(
   parameter int STARVE_MAX = 3,
   parameter int CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a_valid,
   input  logic b_valid,
   output logic grant_a,
   output logic grant_b
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_p0;

   always_comb begin
      grant_b = en & b_valid & (~a_valid | (starve_cnt_p0 == CNT_MAX));
      grant_a = en & a_valid & ~grant_b;
   end

   // Counter only moves while arbitration is live; an idle B forgets its history.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_p0 <= '0;
      end else if (en) begin
         if (grant_b || !b_valid) begin
            starve_cnt_p0 <= '0;
         end else if (grant_a && (starve_cnt_p0 != CNT_MAX)) begin
            starve_cnt_p0 <= starve_cnt_p0 + 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port sequencer: clears the file after reset, then shares
// the port between the WB stage (A) and a multi-cycle unit (B).
module regfile_write_ctrl #(
   parameter int DATA_W     = regfile_pkg::DATA_W,
   parameter int ADDR_W     = regfile_pkg::ADDR_W,
   parameter int NREG       = regfile_pkg::NREG,
   parameter int ZERO_REG   = regfile_pkg::ZERO_REG,
   parameter int STARVE_MAX = regfile_pkg::STARVE_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              init_busy
);

   import regfile_pkg::*;

   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(NREG - 2);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   wctl_state_t       state_p0, state_d;
   logic [ADDR_W-1:0] clr_cnt_p0, clr_cnt_d;
   logic              wr_en_p1, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_p1, wr_addr_d;
   logic [DATA_W-1:0] wr_data_p1, wr_data_d;
   logic              busy_p1, busy_d;

   logic              arb_en;
   logic              grant_a, grant_b;
   logic [ADDR_W-1:0] xfer_addr;
   logic [DATA_W-1:0] xfer_data;

   // Ready must stay low during reset even when the FSM still sits in RUN.
   assign arb_en = (state_p0 == RUN) & ~reset;

   wb_starve_arbiter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clk     (clk),
      .rst     (reset),
      .en      (arb_en),
      .a_valid (a_valid),
      .b_valid (b_valid),
      .grant_a (grant_a),
      .grant_b (grant_b)
   );

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_comb begin
      state_d   = state_p0;
      clr_cnt_d = clr_cnt_p0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_p1;
      wr_data_d = wr_data_p1;
      busy_d    = busy_p1;
      xfer_addr = grant_b ? b_addr : a_addr;
      xfer_data = grant_b ? b_data : a_data;

      case (state_p0)
         INIT: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_cnt_p0;
            wr_data_d = '0;
            // The hardwired-zero register is last, so the clear stops one short of it.
            if (clr_cnt_p0 == CLR_LAST) begin
               state_d = RUN;
               busy_d  = 1'b0;
            end else begin
               clr_cnt_d = clr_cnt_p0 + 1'b1;
            end
         end
         RUN: begin
            if ((grant_a || grant_b) && (xfer_addr != ZERO_ADDR)) begin
               wr_en_d   = 1'b1;
               wr_addr_d = xfer_addr;
               wr_data_d = xfer_data;
            end
         end
      endcase
   end

   // p0 -> p1: state and the registered write port
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p0   <= INIT;
         clr_cnt_p0 <= '0;
         wr_en_p1   <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
         busy_p1    <= 1'b1;
      end else begin
         state_p0   <= state_d;
         clr_cnt_p0 <= clr_cnt_d;
         wr_en_p1   <= wr_en_d;
         wr_addr_p1 <= wr_addr_d;
         wr_data_p1 <= wr_data_d;
         busy_p1    <= busy_d;
      end
   end

   assign wr_en     = wr_en_p1;
   assign wr_addr   = wr_addr_p1;
   assign wr_data   = wr_data_p1;
   assign init_busy = busy_p1;

endmodule
